// File: rtl/spikes_phase_controller_pkg.sv
// Shared types and default timing for the spike hazard layer.
// The bitmap, the collision logic and the phase controller all use these values.
package spikes_phase_controller_pkg;

    // Controller states; the low two bits double as the reported phase code
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RETRACTED = 3'd1,
        S_WARNING   = 3'd2,
        S_EXTENDED  = 3'd3,
        S_LOAD      = 3'd4
    } spike_phase_t;

    localparam int DEF_RETRACT_FRAMES = 120;
    localparam int DEF_WARN_FRAMES    = 60;
    localparam int DEF_EXTEND_FRAMES  = 90;
    localparam int DEF_BLINK_LOG2     = 3;
    localparam int DEF_NUM_LAYOUTS    = 5;

    // Limit a requested layout index to the last layout the bitmap holds
    function automatic logic [3:0] clamp_layout(input logic [3:0] req,
                                                input logic [3:0] max_idx);
        return (req > max_idx) ? max_idx : req;
    endfunction

endpackage

// File: rtl/spikes_phase_controller_frame_tick_counter.sv
// Eight-bit frame counter for the spike phase controller.
// Counts qualified frame ticks and flags the tick that ends the current phase.
module frame_tick_counter (
    input  logic       clk,
    input  logic       resetN,
    input  logic       clear,
    input  logic       tick,
    input  logic [7:0] limit,
    output logic [7:0] count,
    output logic       terminal
);

    // The ending tick is the one that arrives while the count sits on limit-1
    assign terminal = tick & (count == (limit - 8'd1));

    // Count qualified frames; clear wins over tick so a state entry restarts at zero
    always_ff @(posedge clk) begin
        if (!resetN) begin
            count <= 8'd0;
        end else if (clear) begin
            count <= 8'd0;
        end else if (tick) begin
            count <= count + 8'd1;
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/spikes_phase_controller.sv
// Spike phase sequencer: selects the layout, holds the bitmap in reload while idle,
// and cycles the spikes through retracted, blinking warning and lethal extended phases.
module spikes_phase_controller
    import spikes_phase_controller_pkg::*;
#(
    parameter int RETRACT_FRAMES = DEF_RETRACT_FRAMES,
    parameter int WARN_FRAMES    = DEF_WARN_FRAMES,
    parameter int EXTEND_FRAMES  = DEF_EXTEND_FRAMES,
    parameter int BLINK_LOG2     = DEF_BLINK_LOG2,
    parameter int NUM_LAYOUTS    = DEF_NUM_LAYOUTS
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       game_on,
    input  logic       pause,
    input  logic [3:0] level_num,
    output logic [3:0] layout_sel,
    output logic       bitmap_run,
    output logic       spikes_visible,
    output logic       spikes_lethal,
    output logic [1:0] phase,
    output logic       phase_done
);

    localparam logic [3:0] MAX_LAYOUT = 4'(NUM_LAYOUTS - 1);

    spike_phase_t state;
    logic         tick;
    logic         clear;
    logic         terminal;
    logic [7:0]   limit;
    logic [7:0]   count;
    logic [7:0]   count_step;

    assign tick  = startOfFrame & ~pause;
    // Counter restarts on any state entry: held in IDLE/LOAD, cleared on phase end or exit
    assign clear = ~game_on | (state == S_IDLE) | (state == S_LOAD) | terminal;
    // Counter value after this edge when staying in the phase; drives the blink ahead of time
    assign count_step = tick ? (count + 8'd1) : count;
    // LOAD encodes as 3'b100 so its low bits already report phase 0
    assign phase = state[1:0];

    // Select the duration of the phase currently running
    always_comb begin
        limit = 8'd0;
        case (state)
            S_RETRACTED: limit = 8'(RETRACT_FRAMES);
            S_WARNING:   limit = 8'(WARN_FRAMES);
            S_EXTENDED:  limit = 8'(EXTEND_FRAMES);
            default:     limit = 8'd0;
        endcase
    end

    frame_tick_counter u_counter (
        .clk      (clk),
        .resetN   (resetN),
        .clear    (clear),
        .tick     (tick),
        .limit    (limit),
        .count    (count),
        .terminal (terminal)
    );

    // Phase FSM with all outputs registered against the next state
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state          <= S_IDLE;
            layout_sel     <= 4'd0;
            bitmap_run     <= 1'b0;
            spikes_visible <= 1'b0;
            spikes_lethal  <= 1'b0;
            phase_done     <= 1'b0;
        end else begin
            phase_done <= 1'b0;
            if (!game_on) begin
                // Round over: drop to IDLE from anywhere; layout follows level only once idle
                state          <= S_IDLE;
                bitmap_run     <= 1'b0;
                spikes_visible <= 1'b0;
                spikes_lethal  <= 1'b0;
                if (state == S_IDLE) begin
                    layout_sel <= clamp_layout(level_num, MAX_LAYOUT);
                end else begin
                    layout_sel <= layout_sel;
                end
            end else begin
                case (state)
                    S_IDLE: begin
                        layout_sel     <= clamp_layout(level_num, MAX_LAYOUT);
                        state          <= S_LOAD;
                        bitmap_run     <= 1'b0;
                        spikes_visible <= 1'b0;
                        spikes_lethal  <= 1'b0;
                    end
                    S_LOAD: begin
                        state          <= S_RETRACTED;
                        bitmap_run     <= 1'b1;
                        spikes_visible <= 1'b0;
                        spikes_lethal  <= 1'b0;
                    end
                    S_RETRACTED: begin
                        bitmap_run    <= 1'b1;
                        spikes_lethal <= 1'b0;
                        if (terminal) begin
                            state          <= S_WARNING;
                            phase_done     <= 1'b1;
                            spikes_visible <= 1'b1;
                        end else begin
                            spikes_visible <= 1'b0;
                        end
                    end
                    S_WARNING: begin
                        bitmap_run <= 1'b1;
                        if (terminal) begin
                            state          <= S_EXTENDED;
                            phase_done     <= 1'b1;
                            spikes_visible <= 1'b1;
                            spikes_lethal  <= 1'b1;
                        end else begin
                            spikes_visible <= ~count_step[BLINK_LOG2];
                            spikes_lethal  <= 1'b0;
                        end
                    end
                    S_EXTENDED: begin
                        bitmap_run <= 1'b1;
                        if (terminal) begin
                            state          <= S_RETRACTED;
                            phase_done     <= 1'b1;
                            spikes_visible <= 1'b0;
                            spikes_lethal  <= 1'b0;
                        end else begin
                            spikes_visible <= 1'b1;
                            spikes_lethal  <= 1'b1;
                        end
                    end
                    default: begin
                        state          <= S_IDLE;
                        bitmap_run     <= 1'b0;
                        spikes_visible <= 1'b0;
                        spikes_lethal  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spikes_phase_controller.sv
// Directed bench for spikes_phase_controller with default timing parameters.
module tb_spikes_phase_controller;

    logic       clk = 1'b0;
    logic       resetN;
    logic       startOfFrame;
    logic       game_on;
    logic       pause;
    logic [3:0] level_num;
    logic [3:0] layout_sel;
    logic       bitmap_run;
    logic       spikes_visible;
    logic       spikes_lethal;
    logic [1:0] phase;
    logic       phase_done;

    int checks = 0;
    int errors = 0;

    spikes_phase_controller #(
        .RETRACT_FRAMES (120),
        .WARN_FRAMES    (60),
        .EXTEND_FRAMES  (90),
        .BLINK_LOG2     (3),
        .NUM_LAYOUTS    (5)
    ) dut (
        .clk            (clk),
        .resetN         (resetN),
        .startOfFrame   (startOfFrame),
        .game_on        (game_on),
        .pause          (pause),
        .level_num      (level_num),
        .layout_sel     (layout_sel),
        .bitmap_run     (bitmap_run),
        .spikes_visible (spikes_visible),
        .spikes_lethal  (spikes_lethal),
        .phase          (phase),
        .phase_done     (phase_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample point is 1 time unit after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Each frame: one cycle with startOfFrame high, one cycle low
    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            startOfFrame = 1'b1;
            step();
            startOfFrame = 1'b0;
            step();
        end
    endtask

    initial begin
        resetN = 1'b0; startOfFrame = 1'b0; game_on = 1'b0; pause = 1'b0; level_num = 4'd7;
        step(); step();
        chk("rst_layout", 8'(layout_sel), 8'd0);
        chk("rst_phase", 8'(phase), 8'd0);
        chk("rst_flags", {4'd0, bitmap_run, spikes_visible, spikes_lethal, phase_done}, 8'd0);

        resetN = 1'b1;
        step();
        chk("idle_clamp", 8'(layout_sel), 8'd4);
        chk("idle_run", 8'(bitmap_run), 8'd0);
        level_num = 4'd2;
        step();
        chk("idle_layout2", 8'(layout_sel), 8'd2);

        // Start a round; the frame pulse during LOAD must not count
        game_on = 1'b1;
        step();
        chk("load_phase", 8'(phase), 8'd0);
        chk("load_run", 8'(bitmap_run), 8'd0);
        startOfFrame = 1'b1;
        step();
        startOfFrame = 1'b0;
        chk("retr_phase", 8'(phase), 8'd1);
        chk("retr_run", 8'(bitmap_run), 8'd1);
        level_num = 4'd3;
        step();

        frames(119);
        chk("retr_119", 8'(phase), 8'd1);
        chk("retr_119_done", 8'(phase_done), 8'd0);
        startOfFrame = 1'b1;
        step();
        startOfFrame = 1'b0;
        chk("warn_enter", 8'(phase), 8'd2);
        chk("warn_done", 8'(phase_done), 8'd1);
        chk("warn_vis0", 8'(spikes_visible), 8'd1);
        step();
        chk("warn_done_clr", 8'(phase_done), 8'd0);

        // Blink: visible for counts 0-7, hidden 8-15, visible from 16
        frames(7);
        chk("blink_7", 8'(spikes_visible), 8'd1);
        frames(1);
        chk("blink_8", 8'(spikes_visible), 8'd0);
        chk("blink_8_leth", 8'(spikes_lethal), 8'd0);
        frames(7);
        chk("blink_15", 8'(spikes_visible), 8'd0);
        frames(1);
        chk("blink_16", 8'(spikes_visible), 8'd1);
        frames(43);
        chk("warn_59", 8'(phase), 8'd2);
        chk("warn_59_leth", 8'(spikes_lethal), 8'd0);
        startOfFrame = 1'b1;
        step();
        startOfFrame = 1'b0;
        chk("ext_enter", 8'(phase), 8'd3);
        chk("ext_done", 8'(phase_done), 8'd1);
        chk("ext_leth", {6'd0, spikes_visible, spikes_lethal}, 8'd3);
        step();

        // Pause 50 frames mid-extended: the phase ends 50 frames late
        frames(40);
        pause = 1'b1;
        frames(50);
        chk("pause_phase", 8'(phase), 8'd3);
        chk("pause_flags", {6'd0, spikes_visible, spikes_lethal}, 8'd3);
        pause = 1'b0;
        frames(49);
        chk("ext_89", 8'(phase), 8'd3);
        startOfFrame = 1'b1;
        step();
        startOfFrame = 1'b0;
        chk("loop_retr", 8'(phase), 8'd1);
        chk("loop_done", 8'(phase_done), 8'd1);
        chk("loop_flags", {6'd0, spikes_visible, spikes_lethal}, 8'd0);
        chk("layout_frozen", 8'(layout_sel), 8'd2);
        step();

        // Second lap, then drop game_on inside EXTENDED together with a terminal-free frame
        frames(120);
        chk("lap2_warn", 8'(phase), 8'd2);
        frames(60);
        chk("lap2_ext", 8'(phase), 8'd3);
        frames(10);
        game_on = 1'b0;
        startOfFrame = 1'b1;
        step();
        startOfFrame = 1'b0;
        chk("off_phase", 8'(phase), 8'd0);
        chk("off_flags", {5'd0, bitmap_run, spikes_visible, spikes_lethal}, 8'd0);
        chk("off_done", 8'(phase_done), 8'd0);
        chk("off_layout_held", 8'(layout_sel), 8'd2);
        step();
        chk("idle_layout3", 8'(layout_sel), 8'd3);

        // Reset during WARNING; a glitch without a clock edge must do nothing
        game_on = 1'b1;
        step(); step();
        frames(120);
        frames(3);
        chk("rw_warn", 8'(phase), 8'd2);
        resetN = 1'b0;
        #2;
        resetN = 1'b1;
        step();
        chk("glitch_phase", 8'(phase), 8'd2);
        chk("glitch_vis", 8'(spikes_visible), 8'd1);
        resetN = 1'b0;
        step();
        chk("srst_phase", 8'(phase), 8'd0);
        chk("srst_layout", 8'(layout_sel), 8'd0);
        chk("srst_flags", {4'd0, bitmap_run, spikes_visible, spikes_lethal, phase_done}, 8'd0);
        resetN = 1'b1;
        step();
        chk("post_rst_load", 8'(phase), 8'd0);
        chk("post_rst_layout", 8'(layout_sel), 8'd3);
        step();
        chk("post_rst_retr", 8'(phase), 8'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
